// File: rtl/prog_inst_memory.sv
// Reloadable instruction memory: one registered fetch per enabled cycle, with a fault flag
// for misaligned or out-of-range PCs, and a streaming load port that rewrites the contents.
module prog_inst_memory #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 128,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W - 2)'(DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t state, state_d;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

  logic [IDX_W-1:0]  ptr, ptr_d;
  logic [DATA_W-1:0] inst_d;
  logic              inst_valid_d;
  logic              fault_d;
  logic              load_done_d;
  logic              wr_en;
  logic              fetch_legal;

  assign fetch_legal = (pc[1:0] == 2'b00) && (pc[ADDR_W-1:2] < DEPTH_LIM);

  assign load_ready = (state == ST_LOAD);
  assign busy       = (state == ST_LOAD);

  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    inst_d       = inst;
    fault_d      = fault;
    inst_valid_d = 1'b0;
    load_done_d  = 1'b0;
    wr_en        = 1'b0;

    case (state)
      ST_RUN: begin
        if (fetch_en) begin
          inst_valid_d = 1'b1;
          if (fetch_legal) begin
            inst_d  = mem[pc[IDX_W+1:2]];
            fault_d = 1'b0;
          end else begin
            inst_d  = NOP_WORD;
            fault_d = 1'b1;
          end
        end
        // A fetch in the same cycle as load_start is still serviced above.
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end

      ST_LOAD: begin
        inst_d  = NOP_WORD;
        fault_d = 1'b0;
        if (load_valid) begin
          wr_en = 1'b1;
          // Stop at the last word slot so the pointer never wraps past DEPTH-1.
          if (load_last || (ptr == LAST_IDX)) begin
            state_d     = ST_RUN;
            load_done_d = 1'b1;
          end else begin
            ptr_d = ptr + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      ptr        <= '0;
      inst       <= NOP_WORD;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      inst       <= inst_d;
      inst_valid <= inst_valid_d;
      fault      <= fault_d;
      load_done  <= load_done_d;
    end
  end

  // Contents survive reset; reset only blocks a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[ptr] <= load_data;
    end
  end

endmodule

// File: tb/tb_prog_inst_memory.sv
// Randomized and directed bench for prog_inst_memory, checked every cycle against a behavioural model.
module tb_prog_inst_memory;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 128;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] NOP    = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_en;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fault;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  prog_inst_memory #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en),
    .inst(inst), .inst_valid(inst_valid), .fault(fault),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: a word array plus "loading" flag and write position.
  logic [31:0] m_mem [DEPTH] = '{default: 32'h0};
  bit          m_loading = 1'b0;
  int          m_pos     = 0;
  logic [31:0] m_inst    = NOP;
  bit          m_valid   = 1'b0;
  bit          m_fault   = 1'b0;
  bit          m_done    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_loading = 1'b0; m_pos = 0; m_inst = NOP;
      m_valid = 1'b0; m_fault = 1'b0; m_done = 1'b0;
    end else if (!m_loading) begin
      m_done  = 1'b0;
      m_valid = fetch_en;
      if (fetch_en) begin
        if ((pc % 4 == 0) && (pc / 4 < DEPTH)) begin
          m_inst = m_mem[pc / 4]; m_fault = 1'b0;
        end else begin
          m_inst = NOP; m_fault = 1'b1;
        end
      end
      if (load_start) begin
        m_loading = 1'b1; m_pos = 0;
      end
    end else begin
      m_inst = NOP; m_valid = 1'b0; m_fault = 1'b0; m_done = 1'b0;
      if (load_valid) begin
        m_mem[m_pos] = load_data;
        if (load_last || m_pos == DEPTH - 1) begin
          m_loading = 1'b0; m_done = 1'b1;
        end else begin
          m_pos++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_inst", inst, m_inst);
      chk("model_valid", 32'(inst_valid), 32'(m_valid));
      chk("model_fault", 32'(fault), 32'(m_fault));
      chk("model_ready", 32'(load_ready), 32'(m_loading));
      chk("model_busy", 32'(busy), 32'(m_loading));
      chk("model_done", 32'(load_done), 32'(m_done));
    end
  end

  task automatic idle();
    rst = 1'b0; fetch_en = 1'b0; pc = '0; load_start = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] addr);
    idle(); fetch_en = 1'b1; pc = addr; step();
  endtask

  task automatic word(input logic [31:0] d, input bit last);
    idle(); load_valid = 1'b1; load_data = d; load_last = last; step();
  endtask

  task automatic start_load();
    idle(); load_start = 1'b1; step();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    chk_en = 1'b1;
    chk("rst_inst", inst, NOP);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    idle(); step();

    // Preload A,B,C then fetch them back
    start_load();
    chk("ready_rise", 32'(load_ready), 32'd1);
    word(32'hAAAA_0001, 1'b0);
    word(32'hBBBB_0002, 1'b0);
    word(32'hCCCC_0003, 1'b1);
    chk("abc_done", 32'(load_done), 32'd1);
    chk("abc_ready_fall", 32'(load_ready), 32'd0);
    idle(); step();
    chk("abc_done_once", 32'(load_done), 32'd0);
    fetch(0);  chk("fetch_a", inst, 32'hAAAA_0001);
    fetch(4);  chk("fetch_b", inst, 32'hBBBB_0002);
    fetch(8);  chk("fetch_c", inst, 32'hCCCC_0003);
    chk("fetch_c_valid", 32'(inst_valid), 32'd1);

    // Faults
    fetch(6);   chk("misaligned_fault", 32'(fault), 32'd1); chk("misaligned_inst", inst, NOP);
    fetch(512); chk("range_fault", 32'(fault), 32'd1);
    fetch(0);   chk("fault_clear", 32'(fault), 32'd0);

    // Stall holds
    fetch(4);
    for (int i = 0; i < 3; i++) begin
      idle(); step();
      chk("stall_hold", inst, 32'hBBBB_0002);
      chk("stall_valid", 32'(inst_valid), 32'd0);
    end

    // Load with a valid gap
    start_load();
    word(32'h1111_1111, 1'b0);
    word(32'h2222_2222, 1'b0);
    idle(); step();
    chk("gap_no_done", 32'(load_done), 32'd0);
    word(32'h3333_3333, 1'b1);
    chk("xyz_done", 32'(load_done), 32'd1);
    fetch(0);  chk("fetch_x", inst, 32'h1111_1111);
    fetch(4);  chk("fetch_y", inst, 32'h2222_2222);
    fetch(8);  chk("fetch_z", inst, 32'h3333_3333);
    fetch(12); chk("fetch_old", inst, NOP);

    // Overlong burst stops at DEPTH-1
    start_load();
    for (int i = 0; i < 130; i++) begin
      word(32'h1000_0000 + 32'(i), 1'b0);
      chk("burst_done", 32'(load_done), 32'(i == DEPTH - 1));
      chk("burst_ready", 32'(load_ready), 32'(i < DEPTH - 1));
    end
    fetch(508); chk("fetch_last_word", inst, 32'h1000_007F);

    // Reset mid-load
    start_load();
    word(32'hD0D0_0000, 1'b0);
    word(32'hD1D1_0001, 1'b0);
    idle(); rst = 1'b1; load_valid = 1'b1; load_data = 32'hD2D2_0002; step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(load_ready), 32'd0);
    chk("abort_done", 32'(load_done), 32'd0);
    idle(); step();
    chk("abort_no_done", 32'(load_done), 32'd0);
    fetch(0);  chk("abort_w0", inst, 32'hD0D0_0000);
    fetch(4);  chk("abort_w1", inst, 32'hD1D1_0001);
    fetch(8);  chk("abort_w2", inst, 32'h1000_0002);
    fetch(12); chk("abort_w3", inst, 32'h1000_0003);
    fetch(16); chk("abort_w4", inst, 32'h1000_0004);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      fetch_en   = ($urandom_range(0, 3) != 0);
      pc         = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 139)) * 4;
      load_start = ($urandom_range(0, 59) == 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_data  = $urandom;
      load_last  = ($urandom_range(0, 19) == 0);
      step();
    end

    idle(); step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
